// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, instruction field positions and a field slicer.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_INC     = 4;
  localparam int OPCODE_MSB = 31;
  localparam int RS_MSB     = 25;
  localparam int RT_MSB     = 20;
  localparam int RD_MSB     = 15;
  localparam int IMM_W      = 16;
  localparam int OPCODE_W   = 6;
  localparam int REG_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [IMM_W-1:0]    imm16;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] w);
    instr_fields_t f;
    f.opcode = w[OPCODE_MSB -: OPCODE_W];
    f.rs     = w[RS_MSB -: REG_W];
    f.rt     = w[RT_MSB -: REG_W];
    f.rd     = w[RD_MSB -: REG_W];
    f.imm16  = w[IMM_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction-memory req/ack port plus the decode-facing held instruction.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic                imem_req;
  logic [31:0]         imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                instr_valid;
  logic                decode_ready;
  logic [INSTR_W-1:0]  instr;
  logic [31:0]         instr_pc;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic [IMM_W-1:0]    imm16;
  logic                redirect_valid;
  logic [31:0]         redirect_offset;
  logic                fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
           opcode, rs, rt, rd, imm16, fetch_err,
    input  imem_ack, imem_rdata, decode_ready, redirect_valid, redirect_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
           opcode, rs, rt, rd, imm16, fetch_err,
    output imem_ack, imem_rdata, decode_ready, redirect_valid, redirect_offset
  );

endinterface

// File: rtl/fetch_stage_branch_target_calc.sv
// Next-PC adder: sequential PC, or PC+4 plus the word-scaled sign-extended offset when taken.
module branch_target_calc
  import cpu_pkg::*;
(
  input  logic [31:0] instr_pc_i,
  input  logic        taken_i,
  input  logic [31:0] offset_i,
  output logic [31:0] target_o
);

  logic [31:0] seq_pc;

  // Modulo-2^32 arithmetic; the shift drops the offset's top two bits.
  assign seq_pc   = instr_pc_i + 32'(PC_INC);
  assign target_o = taken_i ? (seq_pc + (offset_i << 2)) : seq_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fetches one word per req/ack, holds it for decode.
// Optional FETCH_TIMEOUT_EN adds an ack timeout that parks the stage in a sticky error state.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic [31:0]        target;
  instr_fields_t      fields;

  branch_target_calc u_btc (
    .instr_pc_i (instr_pc_q),
    .taken_i    (bus.redirect_valid),
    .offset_i   (bus.redirect_offset),
    .target_o   (target)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_hit;

  // Hit on the last allowed REQ cycle; an ack in that same cycle still wins.
  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == REQ && !bus.imem_ack) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_ack) state_d = HOLD;
`ifdef FETCH_TIMEOUT_EN
        else if (timeout_hit) state_d = ERR;
`endif
      end
      HOLD: if (bus.decode_ready) state_d = REQ;
      default: state_d = state_q;
    endcase
  end

  // Acks and redirects are only meaningful in REQ and HOLD respectively.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (state_q == REQ && bus.imem_ack) begin
      instr_d    = bus.imem_rdata;
      instr_pc_d = pc_q;
    end
    if (state_q == HOLD && bus.decode_ready) pc_d = target;
  end

  assign fields = decode_fields(instr_q);

  always_comb begin
    bus.imem_req    = (state_q == REQ);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == HOLD);
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.opcode      = fields.opcode;
    bus.rs          = fields.rs;
    bus.rt          = fields.rt;
    bus.rd          = fields.rd;
    bus.imm16       = fields.imm16;
`ifdef FETCH_TIMEOUT_EN
    bus.fetch_err   = (state_q == ERR);
`else
    bus.fetch_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, branch, stall, wrap, reset mid-request, timeout.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n0 = 1'b0;
  logic rst_n1 = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_stage_if bif0 ();
  fetch_stage_if bif1 ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .bus   (bif0.master)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (bif1.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch0(input logic [31:0] w);
    bif0.imem_ack   = 1'b1;
    bif0.imem_rdata = w;
    tick();
    bif0.imem_ack   = 1'b0;
    bif0.imem_rdata = '0;
  endtask

  task automatic consume0(input logic rv, input logic [31:0] off);
    bif0.decode_ready    = 1'b1;
    bif0.redirect_valid  = rv;
    bif0.redirect_offset = off;
    tick();
    bif0.decode_ready    = 1'b0;
    bif0.redirect_valid  = 1'b0;
    bif0.redirect_offset = '0;
  endtask

  initial begin
    bif0.imem_ack = 1'b0; bif0.imem_rdata = '0; bif0.decode_ready = 1'b0;
    bif0.redirect_valid = 1'b0; bif0.redirect_offset = '0;
    bif1.imem_ack = 1'b0; bif1.imem_rdata = '0; bif1.decode_ready = 1'b0;
    bif1.redirect_valid = 1'b0; bif1.redirect_offset = '0;

    // Reset state
    tick(); tick();
    check("rst_req",   32'(bif0.imem_req), 32'd0);
    check("rst_valid", 32'(bif0.instr_valid), 32'd0);
    check("rst_instr", bif0.instr, 32'd0);
    check("rst_ipc",   bif0.instr_pc, 32'd0);
    check("rst_addr",  bif0.imem_addr, 32'd0);
    check("rst_err",   32'(bif0.fetch_err), 32'd0);
    check("rst1_addr", bif1.imem_addr, 32'hFFFF_FFFC);
    check("rst1_req",  32'(bif1.imem_req), 32'd0);

    // Release: IDLE -> REQ, then a same-cycle ack gives valid two edges after release
    rst_n0 = 1'b1;
    tick();
    check("first_req",   32'(bif0.imem_req), 32'd1);
    check("first_addr",  bif0.imem_addr, 32'h0);
    check("first_valid", 32'(bif0.instr_valid), 32'd0);
    fetch0(32'h2001_FFFF);
    check("f0_valid",  32'(bif0.instr_valid), 32'd1);
    check("f0_req",    32'(bif0.imem_req), 32'd0);
    check("f0_instr",  bif0.instr, 32'h2001_FFFF);
    check("f0_ipc",    bif0.instr_pc, 32'h0);
    check("f0_opcode", 32'(bif0.opcode), 32'h08);
    check("f0_rs",     32'(bif0.rs), 32'd0);
    check("f0_rt",     32'(bif0.rt), 32'd1);
    check("f0_rd",     32'(bif0.rd), 32'd31);
    check("f0_imm",    32'(bif0.imm16), 32'h0000_FFFF);

    consume0(1'b0, 32'h0);
    check("seq1_addr",  bif0.imem_addr, 32'h4);
    check("seq1_req",   32'(bif0.imem_req), 32'd1);
    check("seq1_valid", 32'(bif0.instr_valid), 32'd0);

    // Read data without ack is ignored
    bif0.imem_rdata = 32'hBAD0_BAD0;
    tick();
    bif0.imem_rdata = '0;
    check("noack_valid", 32'(bif0.instr_valid), 32'd0);
    check("noack_addr",  bif0.imem_addr, 32'h4);
    check("noack_instr", bif0.instr, 32'h2001_FFFF);

    fetch0(32'h2002_0004);
    check("f1_imm", 32'(bif0.imm16), 32'h0000_0004);
    check("f1_ipc", bif0.instr_pc, 32'h4);
    check("f1_rt",  32'(bif0.rt), 32'd2);

    // Offset ignored when not taken
    consume0(1'b0, 32'h1234_5678);
    check("seq2_addr", bif0.imem_addr, 32'h8);

    // Offset top bits dropped by the shift: 8+4+4
    fetch0(32'h0);
    consume0(1'b1, 32'h4000_0001);
    check("trunc_addr", bif0.imem_addr, 32'h10);

    // Backward branch: 0x10 + 4 - 16 = 4
    fetch0(32'h1000_FFFF);
    check("br_ipc", bif0.instr_pc, 32'h10);
    check("br_imm", 32'(bif0.imm16), 32'h0000_FFFF);
    consume0(1'b1, 32'hFFFF_FFFC);
    check("br_addr", bif0.imem_addr, 32'h4);

    // Stall five cycles; a mid-stall redirect and a spurious ack are ignored
    fetch0(32'h8C22_0010);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bif0.redirect_valid = 1'b1; bif0.redirect_offset = 32'h100;
        bif0.imem_ack = 1'b1; bif0.imem_rdata = 32'hFFFF_FFFF;
      end
      tick();
      bif0.redirect_valid = 1'b0; bif0.redirect_offset = '0;
      bif0.imem_ack = 1'b0; bif0.imem_rdata = '0;
      check("stall_instr", bif0.instr, 32'h8C22_0010);
      check("stall_valid", 32'(bif0.instr_valid), 32'd1);
      check("stall_req",   32'(bif0.imem_req), 32'd0);
      check("stall_addr",  bif0.imem_addr, 32'h4);
    end
    check("stall_opcode", 32'(bif0.opcode), 32'h23);
    check("stall_rs",     32'(bif0.rs), 32'd1);
    check("stall_rt",     32'(bif0.rt), 32'd2);
    check("stall_imm",    32'(bif0.imm16), 32'h10);
    consume0(1'b0, 32'h0);
    check("post_stall_addr", bif0.imem_addr, 32'h8);

    // Reset during a request with a same-cycle ack
    rst_n0 = 1'b0;
    bif0.imem_ack = 1'b1; bif0.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bif0.imem_ack = 1'b0; bif0.imem_rdata = '0;
    check("rmid_valid", 32'(bif0.instr_valid), 32'd0);
    check("rmid_req",   32'(bif0.imem_req), 32'd0);
    check("rmid_instr", bif0.instr, 32'h0);
    check("rmid_addr",  bif0.imem_addr, 32'h0);
    rst_n0 = 1'b1;
    tick();
    check("rmid_req2",  32'(bif0.imem_req), 32'd1);
    check("rmid_addr2", bif0.imem_addr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Ack on the 4th REQ cycle wins over the timeout
    tick(); tick(); tick();
    check("tmo_pre_req", 32'(bif0.imem_req), 32'd1);
    check("tmo_pre_err", 32'(bif0.fetch_err), 32'd0);
    fetch0(32'h2003_0001);
    check("tmo_late_valid", 32'(bif0.instr_valid), 32'd1);
    check("tmo_late_err",   32'(bif0.fetch_err), 32'd0);
    check("tmo_late_instr", bif0.instr, 32'h2003_0001);
    consume0(1'b0, 32'h0);
    tick(); tick(); tick(); tick();
    check("tmo_err",   32'(bif0.fetch_err), 32'd1);
    check("tmo_req",   32'(bif0.imem_req), 32'd0);
    check("tmo_valid", 32'(bif0.instr_valid), 32'd0);
    bif0.imem_ack = 1'b1; bif0.imem_rdata = 32'h1111_1111;
    tick();
    bif0.imem_ack = 1'b0; bif0.imem_rdata = '0;
    tick(); tick();
    check("tmo_sticky_err",   32'(bif0.fetch_err), 32'd1);
    check("tmo_sticky_req",   32'(bif0.imem_req), 32'd0);
    check("tmo_sticky_valid", 32'(bif0.instr_valid), 32'd0);
    rst_n0 = 1'b0;
    tick();
    check("tmo_rst_err", 32'(bif0.fetch_err), 32'd0);
    rst_n0 = 1'b1;
`else
    // Without the timeout, REQ waits indefinitely
    for (int i = 0; i < 6; i++) tick();
    check("wait_req",  32'(bif0.imem_req), 32'd1);
    check("wait_addr", bif0.imem_addr, 32'h0);
    check("wait_err",  32'(bif0.fetch_err), 32'd0);
    fetch0(32'h2003_0001);
    check("wait_valid", 32'(bif0.instr_valid), 32'd1);
    check("wait_instr", bif0.instr, 32'h2003_0001);
    check("wait_err2",  32'(bif0.fetch_err), 32'd0);
`endif

    // PC wrap from the top word to zero
    rst_n1 = 1'b1;
    tick();
    check("wrap_req",  32'(bif1.imem_req), 32'd1);
    check("wrap_addr", bif1.imem_addr, 32'hFFFF_FFFC);
    bif1.imem_ack = 1'b1; bif1.imem_rdata = 32'h2004_0008;
    tick();
    bif1.imem_ack = 1'b0; bif1.imem_rdata = '0;
    check("wrap_ipc",   bif1.instr_pc, 32'hFFFF_FFFC);
    check("wrap_valid", 32'(bif1.instr_valid), 32'd1);
    bif1.decode_ready = 1'b1;
    tick();
    bif1.decode_ready = 1'b0;
    check("wrap_next_addr", bif1.imem_addr, 32'h0);
    check("wrap_next_req",  32'(bif1.imem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the immediate sign extender in the CPU datapath.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Holds the returned instruction and presents its decoded fields to decode, including the 16-bit immediate imm16 that feeds the sign extender.
- Consumes the sign-extended branch offset back from the datapath to compute redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT_CYCLES, 16, max cycles waiting for imem_ack (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  word-aligned fetch address (= pc).
- imem_ack  in  1  one-cycle response strobe.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instr_valid  out  1  held instruction available to decode.
- decode_ready  in  1  decode consumes the held instruction this cycle.
- instr  out  32  held instruction.
- instr_pc  out  32  PC of the held instruction.
- opcode  out  6  instr[31:26].
- rs, rt, rd  out  5 each  instr[25:21], instr[20:16], instr[15:11].
- imm16  out  16  instr[15:0], drives the sign extender input.
- redirect_valid  in  1  held instruction is a taken branch.
- redirect_offset  in  32  sign-extended imm16 returned from the sign extender.
- fetch_err  out  1  sticky timeout error (0 if feature absent).

Behaviour:
- Reset (rst_n low at clk edge): pc=RESET_PC; state=IDLE; imem_req=0; instr_valid=0; instr=0; instr_pc=0; fetch_err=0. Reset overrides any in-flight request; an ack arriving in the reset cycle is discarded.
- FSM states: IDLE, REQ, HOLD (ERR with feature).
- IDLE -> REQ unconditionally next cycle.
- REQ: imem_req=1 and imem_addr=pc, both stable until ack.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, -> HOLD.
  - Fetch latency is 1 cycle minimum; req and ack in the same cycle is legal.
- HOLD: instr_valid=1, imem_req=0; all field outputs are combinational slices of the instr register and stay stable while held.
  - On decode_ready=1: if redirect_valid, pc<=instr_pc+4+(redirect_offset<<2); else pc<=instr_pc+4. Then instr_valid<=0 and -> REQ next cycle. No zero-cycle refetch, so throughput is at most one instruction per 2 cycles.
- redirect_valid and redirect_offset are sampled only when instr_valid && decode_ready; they are ignored at all other times.
- Arithmetic: 32-bit modulo. pc wraps from 32'hFFFF_FFFC to 0 with no error. The shifted offset discards its top 2 bits. A negative offset moves backwards.
- imem_rdata is ignored without imem_ack. A spurious ack outside REQ is ignored.
- pc[1:0] is always 0; RESET_PC must be word aligned.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: state -> ERR, imem_req=0, fetch_err=1, instr_valid=0.
  - ERR is left only by reset.
  - An ack in the same cycle the count hits the limit wins: the instruction is accepted and no error is raised.
- Undefined: no counter, no ERR state, fetch_err tied 0, and REQ waits indefinitely.

Decomposition:
- Shared package cpu_pkg: fetch_state_t enum (IDLE, REQ, HOLD, ERR); field-position localparams (OPCODE_MSB=31, RS_MSB=25, RT_MSB=20, RD_MSB=15, IMM_W=16); INSTR_W=32; PC_INC=4.
- One natural sub-module, branch_target_calc: combinational, computing instr_pc+4+(offset<<2). All other logic stays in fetch_stage.

Test Plan:
- Reset release with RESET_PC=0 and 1-cycle ack memory -> first imem_addr=0; instr_valid rises 2 cycles after reset deasserts; imm16=instr[15:0].
- Sequential fetch with decode_ready=1 always, memory returning 32'h2001_FFFF, 32'h2002_0004 -> addresses 0, 4, 8; imm16 shows 16'hFFFF then 16'h0004.
- Branch: held instr_pc=32'h0000_0010, redirect_valid=1, redirect_offset=32'hFFFF_FFFC -> next imem_addr=32'h0000_0004.
- Stall: decode_ready=0 for 5 cycles in HOLD -> instr and fields unchanged, imem_req=0, pc unchanged; redirect_valid pulsed mid-stall is ignored.
- Wrap and reset mid-request: RESET_PC=32'hFFFF_FFFC -> second fetch address is 0. rst_n low while imem_req=1 with a same-cycle ack -> instr_valid=0 and imem_addr=RESET_PC afterwards.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> fetch_err=1 after 4 REQ cycles, imem_req=0 permanently until reset. Ack on the 4th cycle -> instruction accepted, fetch_err=0.
